// File: rtl/trap_unit.sv
// Machine-mode trap sequencer: ecall/ebreak/external-irq entry and mret return.
// The mepc/mcause/mstatus updates are spread over one CSR write per cycle, then fetch is redirected.
module trap_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid_i,
    input  logic        ex_stall_i,
    input  logic [31:0] ex_pc_i,
    input  logic        ecall_i,
    input  logic        ebreak_i,
    input  logic        mret_i,
    input  logic        irq_i,
    input  logic [31:0] mstatus_i,
    input  logic [31:0] mtvec_i,
    input  logic [31:0] mepc_i,
    input  logic        mie_meie_i,
    output logic        excp_stallreq_o,
    output logic [2:0]  excp_flushreq_o,
    output logic        excp_jump_req_o,
    output logic [31:0] excp_jump_addr_o,
    output logic        csr_we_o,
    output logic [11:0] csr_waddr_o,
    output logic [31:0] csr_wdata_o
);

    // state        | meaning
    // S_IDLE       | waiting for an acceptable ecall/ebreak/mret/irq
    // S_WR_MEPC    | writing trapping pc to mepc
    // S_WR_MCAUSE  | writing cause code to mcause
    // S_WR_MSTATUS | stacking (trap) or unstacking (mret) MIE/MPIE
    // S_JUMP       | one-cycle redirect of fetch
    typedef enum logic [2:0] {
        S_IDLE, S_WR_MEPC, S_WR_MCAUSE, S_WR_MSTATUS, S_JUMP
    } state_t;

    typedef enum logic [1:0] {K_NONE, K_EXC, K_IRQ, K_MRET} kind_t;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    state_t      state_q;
    kind_t       kind_q;
    kind_t       kind_d;
    logic [31:0] pc_q;
    logic [31:0] cause_q;
    logic [31:0] cause_d;
    logic        accept_ok;
    logic        irq_ok;
    logic [31:0] mstatus_trap;
    logic [31:0] mstatus_mret;
    logic        unused_mtvec;

    assign accept_ok    = ex_valid_i && !ex_stall_i;
    assign irq_ok       = irq_i && mstatus_i[3] && mie_meie_i;
    assign unused_mtvec = ^mtvec_i[1:0];

    // A losing irq is simply ignored here; its level keeps it pending.
    always_comb begin
        kind_d  = K_NONE;
        cause_d = 32'd0;
        if (accept_ok) begin
            if (ecall_i) begin
                kind_d  = K_EXC;
                cause_d = 32'd11;
            end else if (ebreak_i) begin
                kind_d  = K_EXC;
                cause_d = 32'd3;
            end else if (mret_i) begin
                kind_d  = K_MRET;
            end else if (irq_ok) begin
                kind_d  = K_IRQ;
                cause_d = 32'h8000_000B;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            kind_q  <= K_NONE;
            pc_q    <= 32'd0;
            cause_q <= 32'd0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (kind_d != K_NONE) begin
                        pc_q    <= ex_pc_i;
                        cause_q <= cause_d;
                        kind_q  <= kind_d;
                        state_q <= (kind_d == K_MRET) ? S_WR_MSTATUS : S_WR_MEPC;
                    end
                end
                S_WR_MEPC:    state_q <= S_WR_MCAUSE;
                S_WR_MCAUSE:  state_q <= S_WR_MSTATUS;
                S_WR_MSTATUS: state_q <= S_JUMP;
                S_JUMP:       state_q <= S_IDLE;
                default:      state_q <= S_IDLE;
            endcase
        end
    end

    assign mstatus_trap = {mstatus_i[31:8], mstatus_i[3], mstatus_i[6:4], 1'b0, mstatus_i[2:0]};
    assign mstatus_mret = {mstatus_i[31:8], 1'b1, mstatus_i[6:4], mstatus_i[7], mstatus_i[2:0]};

    always_comb begin
        excp_stallreq_o  = 1'b0;
        excp_flushreq_o  = 3'b000;
        excp_jump_req_o  = 1'b0;
        excp_jump_addr_o = 32'd0;
        csr_we_o         = 1'b0;
        csr_waddr_o      = 12'h000;
        csr_wdata_o      = 32'd0;
        case (state_q)
            S_WR_MEPC: begin
                excp_stallreq_o = 1'b1;
                csr_we_o        = 1'b1;
                csr_waddr_o     = CSR_MEPC;
                csr_wdata_o     = pc_q;
            end
            S_WR_MCAUSE: begin
                excp_stallreq_o = 1'b1;
                csr_we_o        = 1'b1;
                csr_waddr_o     = CSR_MCAUSE;
                csr_wdata_o     = cause_q;
            end
            S_WR_MSTATUS: begin
                excp_stallreq_o = 1'b1;
                csr_we_o        = 1'b1;
                csr_waddr_o     = CSR_MSTATUS;
                csr_wdata_o     = (kind_q == K_MRET) ? mstatus_mret : mstatus_trap;
            end
            S_JUMP: begin
                excp_jump_req_o  = 1'b1;
                excp_jump_addr_o = (kind_q == K_MRET) ? mepc_i : {mtvec_i[31:2], 2'b00};
            end
            default: ;
        endcase
        // Flush fires only in the first cycle after accept.
        if (state_q == S_WR_MEPC || (state_q == S_WR_MSTATUS && kind_q == K_MRET)) begin
            case (kind_q)
                K_EXC:   excp_flushreq_o = 3'b001;
                K_IRQ:   excp_flushreq_o = 3'b010;
                K_MRET:  excp_flushreq_o = 3'b100;
                default: excp_flushreq_o = 3'b000;
            endcase
        end
    end

endmodule
